// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - handshake/control bundle between datapath and mc_control_fsm
//
// Purpose: groups every non-clock/reset signal of the multi-cycle control FSM.
// Modports:
//   master - datapath/memory side: drives run, opcode, zero, mem_ready;
//            observes state and all control strobes.
//   slave  - the control FSM: samples the inputs above, drives
//            state, busy, error, mem_req, mem_sel, weIR, wePc, pc_src,
//            weReg, weMem, alu_src, wb_sel, aluop, instr_done.

interface mc_control_fsm_if;
  logic       run;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic [3:0] state;
  logic       busy;
  logic       error;
  logic       mem_req;
  logic       mem_sel;
  logic       weIR;
  logic       wePc;
  logic [1:0] pc_src;
  logic       weReg;
  logic       weMem;
  logic       alu_src;
  logic       wb_sel;
  logic [1:0] aluop;
  logic       instr_done;

  modport master (
    output run, opcode, zero, mem_ready,
    input  state, busy, error, mem_req, mem_sel, weIR, wePc, pc_src,
           weReg, weMem, alu_src, wb_sel, aluop, instr_done
  );

  modport slave (
    input  run, opcode, zero, mem_ready,
    output state, busy, error, mem_req, mem_sel, weIR, wePc, pc_src,
           weReg, weMem, alu_src, wb_sel, aluop, instr_done
  );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle CPU control FSM (fetch/decode/execute/mem/write-back)
//
// Purpose: sequences one instruction at a time through FETCH, DECODE, EXECUTE,
// MEM and WRITE_BACK, producing datapath write enables and mux selects, with a
// memory-wait watchdog that parks the FSM in ERROR until reset.
// Parameter:
//   TIMEOUT_CYC - consecutive memory-wait cycles tolerated before fault (1..255)
// Ports:
//   clk   - clock, all state updates on its rising edge
//   reset - asynchronous active-high reset
//   bus   - mc_control_fsm_if.slave: run/opcode/zero/mem_ready in;
//           state and control strobes out (all combinational from state,
//           latched opcode and mem_ready)
// Build option:
//   MC_CTRL_BRANCH_EN - when defined, BEQ (1100011) executes as a branch;
//                       otherwise it is an illegal opcode and pc_src stays 00.

module mc_control_fsm #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input logic             clk,
  input logic             reset,
  mc_control_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_EXECUTE    = 4'd3,
    S_MEM        = 4'd4,
    S_WRITE_BACK = 4'd5,
    S_ERROR      = 4'd6
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // The wait cycle whose count would bring the counter up to TIMEOUT_CYC.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [6:0] opcode_q, opcode_d;

  logic       busy_c, error_c, mem_req_c, mem_sel_c, weir_c, wepc_c;
  logic [1:0] pc_src_c;
  logic       wereg_c, wemem_c, alu_src_c, wb_sel_c;
  logic [1:0] aluop_c;
  logic       instr_done_c;

  logic       is_lw, is_sw;
  logic       decode_legal;

  assign is_lw = (opcode_q == OP_LW);
  assign is_sw = (opcode_q == OP_SW);

`ifdef MC_CTRL_BRANCH_EN
  assign decode_legal = (bus.opcode == OP_LW) || (bus.opcode == OP_SW) ||
                        (bus.opcode == OP_R)  || (bus.opcode == OP_I)  ||
                        (bus.opcode == OP_BEQ);
`else
  assign decode_legal = (bus.opcode == OP_LW) || (bus.opcode == OP_SW) ||
                        (bus.opcode == OP_R)  || (bus.opcode == OP_I);
  // The zero flag only matters to branches.
  logic unused_zero;
  assign unused_zero = bus.zero;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wait_q   <= 8'd0;
      opcode_q <= 7'd0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = 8'd0;
    opcode_d     = opcode_q;
    busy_c       = 1'b0;
    error_c      = 1'b0;
    mem_req_c    = 1'b0;
    mem_sel_c    = 1'b0;
    weir_c       = 1'b0;
    wepc_c       = 1'b0;
    pc_src_c     = 2'b00;
    wereg_c      = 1'b0;
    wemem_c      = 1'b0;
    alu_src_c    = 1'b0;
    wb_sel_c     = 1'b0;
    aluop_c      = 2'b00;
    instr_done_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end

      S_FETCH: begin
        busy_c    = 1'b1;
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          weir_c  = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        busy_c   = 1'b1;
        opcode_d = bus.opcode;
        state_d  = decode_legal ? S_EXECUTE : S_ERROR;
      end

      S_EXECUTE: begin
        busy_c = 1'b1;
        case (opcode_q)
          OP_LW, OP_SW: begin
            alu_src_c = 1'b1;
            state_d   = S_MEM;
          end
          OP_R: begin
            aluop_c = 2'b10;
            state_d = S_WRITE_BACK;
          end
          OP_I: begin
            aluop_c   = 2'b10;
            alu_src_c = 1'b1;
            state_d   = S_WRITE_BACK;
          end
`ifdef MC_CTRL_BRANCH_EN
          // Branch resolves and retires here; no MEM or WRITE_BACK.
          OP_BEQ: begin
            aluop_c      = 2'b01;
            wepc_c       = 1'b1;
            instr_done_c = 1'b1;
            pc_src_c     = bus.zero ? 2'b01 : 2'b00;
            state_d      = bus.run ? S_FETCH : S_IDLE;
          end
`endif
          default: state_d = S_ERROR;
        endcase
      end

      S_MEM: begin
        busy_c    = 1'b1;
        mem_req_c = 1'b1;
        mem_sel_c = 1'b1;
        alu_src_c = 1'b1;
        wemem_c   = is_sw;
        if (bus.mem_ready) begin
          if (is_sw) begin
            wepc_c       = 1'b1;
            instr_done_c = 1'b1;
            state_d      = bus.run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WRITE_BACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WRITE_BACK: begin
        busy_c       = 1'b1;
        wereg_c      = 1'b1;
        wb_sel_c     = is_lw;
        wepc_c       = 1'b1;
        instr_done_c = 1'b1;
        state_d      = bus.run ? S_FETCH : S_IDLE;
      end

      S_ERROR: begin
        error_c = 1'b1;
      end

      default: state_d = S_ERROR;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.busy       = busy_c;
  assign bus.error      = error_c;
  assign bus.mem_req    = mem_req_c;
  assign bus.mem_sel    = mem_sel_c;
  assign bus.weIR       = weir_c;
  assign bus.wePc       = wepc_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.weReg      = wereg_c;
  assign bus.weMem      = wemem_c;
  assign bus.alu_src    = alu_src_c;
  assign bus.wb_sel     = wb_sel_c;
  assign bus.aluop      = aluop_c;
  assign bus.instr_done = instr_done_c;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard testbench for mc_control_fsm

module tb_mc_control_fsm;

  logic clk;
  logic reset;

  mc_control_fsm_if bus ();

  mc_control_fsm #(.TIMEOUT_CYC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Flag masks, packed as busy,error,mem_req,mem_sel,weIR,wePc,pc_src[1:0],
  // weReg,weMem,alu_src,wb_sel,aluop[1:0],instr_done.
  localparam logic [14:0] BUSY  = 15'h4000;
  localparam logic [14:0] ERR   = 15'h2000;
  localparam logic [14:0] MREQ  = 15'h1000;
  localparam logic [14:0] MSEL  = 15'h0800;
  localparam logic [14:0] WEIR  = 15'h0400;
  localparam logic [14:0] WEPC  = 15'h0200;
  localparam logic [14:0] PCBR  = 15'h0080;
  localparam logic [14:0] WEREG = 15'h0040;
  localparam logic [14:0] WEMEM = 15'h0020;
  localparam logic [14:0] ASRC  = 15'h0010;
  localparam logic [14:0] WBSEL = 15'h0008;
  localparam logic [14:0] AOP10 = 15'h0004;
  localparam logic [14:0] AOP01 = 15'h0002;
  localparam logic [14:0] DONE  = 15'h0001;
  localparam logic [14:0] NONE  = 15'h0000;

  int n_checks = 0;
  int n_errors = 0;

  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];

  function automatic logic [18:0] mk(input logic [3:0] st, input logic [14:0] f);
    return {st, f};
  endfunction

  function automatic logic [18:0] outs();
    return {bus.state, bus.busy, bus.error, bus.mem_req, bus.mem_sel, bus.weIR,
            bus.wePc, bus.pc_src, bus.weReg, bus.weMem, bus.alu_src, bus.wb_sel,
            bus.aluop, bus.instr_done};
  endfunction

  // One cycle: drive inputs, record the expected outputs for this cycle,
  // capture what the DUT shows at mid-cycle, then move past the next edge.
  task automatic apply(input logic run, input logic [6:0] op, input logic z,
                       input logic mr, input logic [18:0] expv);
    bus.run       = run;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = mr;
    exp_q.push_back(expv);
    @(negedge clk);
    obs_q.push_back(outs());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.run = 1'b0; bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] got;
    bus.run = 1'b1; bus.opcode = OP_R; bus.zero = 1'b1; bus.mem_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = outs();
      n_checks++;
      if (got !== mk(4'd0, NONE)) begin
        n_errors++;
        $display("FAIL reset[%0d] got=%h want=%h", i, got, mk(4'd0, NONE));
      end
    end
    do_reset();
  endtask

  task automatic test_r_type();
    do_reset();
    apply(1, OP_R, 0, 1, mk(0, NONE));
    apply(1, OP_R, 0, 1, mk(1, BUSY|MREQ|WEIR));
    apply(1, OP_R, 0, 1, mk(2, BUSY));
    apply(1, OP_R, 0, 1, mk(3, BUSY|AOP10));
    apply(1, OP_R, 0, 1, mk(5, BUSY|WEREG|WEPC|DONE));
    apply(1, OP_R, 0, 1, mk(1, BUSY|MREQ|WEIR));
    while (exp_q.size() != 0) begin
      logic [18:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL r_type got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_lw_wait();
    do_reset();
    apply(1, OP_LW, 0, 1, mk(0, NONE));
    apply(1, OP_LW, 0, 1, mk(1, BUSY|MREQ|WEIR));
    apply(1, OP_LW, 0, 1, mk(2, BUSY));
    // opcode changes after DECODE must not matter
    apply(1, OP_R,  0, 0, mk(3, BUSY|ASRC));
    apply(1, OP_R,  0, 0, mk(4, BUSY|MREQ|MSEL|ASRC));
    apply(1, OP_R,  0, 0, mk(4, BUSY|MREQ|MSEL|ASRC));
    apply(1, OP_R,  0, 0, mk(4, BUSY|MREQ|MSEL|ASRC));
    // fourth MEM cycle: handshake on the last tolerated wait, no fault
    apply(1, OP_R,  0, 1, mk(4, BUSY|MREQ|MSEL|ASRC));
    apply(0, OP_R,  0, 1, mk(5, BUSY|WEREG|WBSEL|WEPC|DONE));
    apply(0, OP_R,  0, 1, mk(0, NONE));
    while (exp_q.size() != 0) begin
      logic [18:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL lw_wait got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_sw();
    do_reset();
    apply(1, OP_SW, 0, 0, mk(0, NONE));
    apply(1, OP_SW, 0, 0, mk(1, BUSY|MREQ));
    apply(1, OP_SW, 0, 1, mk(1, BUSY|MREQ|WEIR));
    apply(1, OP_SW, 0, 1, mk(2, BUSY));
    apply(1, OP_SW, 0, 0, mk(3, BUSY|ASRC));
    apply(1, OP_SW, 0, 0, mk(4, BUSY|MREQ|MSEL|ASRC|WEMEM));
    apply(1, OP_SW, 0, 1, mk(4, BUSY|MREQ|MSEL|ASRC|WEMEM|WEPC|DONE));
    apply(1, OP_SW, 0, 0, mk(1, BUSY|MREQ));
    while (exp_q.size() != 0) begin
      logic [18:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL sw got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    apply(1, OP_I, 0, 1, mk(0, NONE));
    apply(1, OP_I, 0, 1, mk(1, BUSY|MREQ|WEIR));
    apply(1, OP_I, 0, 1, mk(2, BUSY));
    apply(1, OP_I, 0, 1, mk(3, BUSY|AOP10|ASRC));
    apply(1, OP_I, 0, 1, mk(5, BUSY|WEREG|WEPC|DONE));
    apply(1, OP_R, 0, 1, mk(1, BUSY|MREQ|WEIR));
    // run drops mid-instruction: the R op still completes
    apply(0, OP_R, 0, 1, mk(2, BUSY));
    apply(0, OP_R, 0, 1, mk(3, BUSY|AOP10));
    apply(0, OP_R, 0, 1, mk(5, BUSY|WEREG|WEPC|DONE));
    apply(0, OP_R, 0, 1, mk(0, NONE));
    apply(0, OP_R, 0, 1, mk(0, NONE));
    while (exp_q.size() != 0) begin
      logic [18:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL back_to_back got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    apply(1, OP_R, 0, 0, mk(0, NONE));
    for (int i = 0; i < 4; i++) apply(1, OP_R, 0, 0, mk(1, BUSY|MREQ));
    apply(1, OP_R, 0, 1, mk(6, ERR));
    apply(1, OP_R, 0, 1, mk(6, ERR));
    apply(0, OP_R, 0, 0, mk(6, ERR));
    while (exp_q.size() != 0) begin
      logic [18:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL timeout got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_opcodes();
    do_reset();
    apply(1, OP_BEQ, 1, 1, mk(0, NONE));
    apply(1, OP_BEQ, 1, 1, mk(1, BUSY|MREQ|WEIR));
    apply(1, OP_BEQ, 1, 1, mk(2, BUSY));
`ifdef MC_CTRL_BRANCH_EN
    apply(1, OP_BEQ, 1, 1, mk(3, BUSY|AOP01|WEPC|PCBR|DONE));
    apply(1, OP_BEQ, 0, 1, mk(1, BUSY|MREQ|WEIR));
    apply(1, OP_BEQ, 0, 1, mk(2, BUSY));
    apply(0, OP_BEQ, 0, 1, mk(3, BUSY|AOP01|WEPC|DONE));
    apply(0, OP_BEQ, 0, 1, mk(0, NONE));
`else
    apply(1, OP_BEQ, 1, 1, mk(6, ERR));
`endif
    do_reset();
    apply(1, OP_BAD, 0, 1, mk(0, NONE));
    apply(1, OP_BAD, 0, 1, mk(1, BUSY|MREQ|WEIR));
    apply(1, OP_BAD, 0, 1, mk(2, BUSY));
    apply(1, OP_BAD, 0, 1, mk(6, ERR));
    while (exp_q.size() != 0) begin
      logic [18:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL opcodes got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [18:0] got;
    do_reset();
    apply(1, OP_SW, 0, 1, mk(0, NONE));
    apply(1, OP_SW, 0, 1, mk(1, BUSY|MREQ|WEIR));
    apply(1, OP_SW, 0, 0, mk(2, BUSY));
    apply(1, OP_SW, 0, 0, mk(3, BUSY|ASRC));
    apply(1, OP_SW, 0, 1, mk(4, BUSY|MREQ|MSEL|ASRC|WEMEM|WEPC|DONE));
    // now in FETCH of the next instruction; rewind into MEM of a fresh SW
    do_reset();
    apply(1, OP_SW, 0, 1, mk(0, NONE));
    apply(1, OP_SW, 0, 1, mk(1, BUSY|MREQ|WEIR));
    apply(1, OP_SW, 0, 0, mk(2, BUSY));
    apply(1, OP_SW, 0, 1, mk(3, BUSY|ASRC));
    // in MEM with mem_ready=1: assert reset mid-cycle
    #2 reset = 1'b1;
    #1 got = outs();
    n_checks++;
    if (got !== mk(0, NONE)) begin
      n_errors++;
      $display("FAIL reset_in_mem got=%h want=%h", got, mk(0, NONE));
    end
    @(posedge clk);
    #1 reset = 1'b0;
    apply(0, OP_SW, 0, 1, mk(0, NONE));
    apply(0, OP_SW, 0, 1, mk(0, NONE));
    apply(0, OP_SW, 0, 1, mk(0, NONE));
    while (exp_q.size() != 0) begin
      logic [18:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reset_mid_sw got=%h want=%h", o, e); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.run = 1'b0; bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_sw();
    test_back_to_back();
    test_timeout();
    test_opcodes();
    test_reset_mid_sw();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 15, maximum consecutive memory-wait cycles before fault (range 1..255).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 run  in  1  level enable; high = keep issuing instructions.
REQ-005 opcode  in  7  instruction opcode field from the IR; sampled in DECODE only.
REQ-006 zero  in  1  ALU zero flag; sampled in EXECUTE only.
REQ-007 mem_ready  in  1  memory handshake; high = access completes this cycle.
REQ-008 state  out  4  current state encoding.
REQ-009 Outputs, 1 bit each unless noted: busy, error, mem_req, mem_sel (0 = PC address, 1 = ALU address), weIR, wePc, pc_src (2 bits: 00 = PC+4, 01 = branch target), weReg, weMem, alu_src (1 = immediate), wb_sel (1 = memory data), aluop (2 bits), instr_done.

Function
REQ-010 States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITE_BACK=5, ERROR=6; other codes SHALL go to ERROR on the next edge.
REQ-011 Outputs SHALL be combinational decodes of the state register, the latched opcode and mem_ready; every output not named active in a state SHALL be 0.
REQ-012 IDLE: run=1 -> FETCH; else stay; busy=0.
REQ-013 FETCH: mem_req=1, mem_sel=0; mem_ready=1 -> weIR=1 in that same cycle, then DECODE; mem_ready=0 -> stay.
REQ-014 DECODE: opcode SHALL latch into an internal register; supported opcodes (LW 0000011, SW 0100011, R 0110011, I 0010011) -> EXECUTE; any other opcode -> ERROR.
REQ-015 EXECUTE: aluop=00 for LW/SW, 10 for R/I; alu_src=1 for LW/SW/I; LW/SW -> MEM; R/I -> WRITE_BACK.
REQ-016 MEM: mem_req=1, mem_sel=1, alu_src=1, aluop=00; weMem=1 for SW only; on mem_ready, LW -> WRITE_BACK, SW -> completion.
REQ-017 WRITE_BACK: weReg=1; wb_sel=1 for LW, else 0; single cycle, then completion.
REQ-018 Completion cycle (WRITE_BACK, or MEM with mem_ready for SW): wePc=1, pc_src=00, instr_done=1; next state FETCH if run=1, else IDLE.
REQ-019 run falling mid-instruction SHALL NOT abort it; the instruction completes, then the FSM goes IDLE.
REQ-020 busy=1 in every state except IDLE and ERROR.
REQ-021 Wait counter (8 bit): increments each cycle in FETCH or MEM with mem_ready=0; clears on mem_ready=1 or on any other state; when it reaches TIMEOUT_CYC while mem_ready=0, the next state SHALL be ERROR.
REQ-022 If mem_ready=1 in the same cycle the counter reaches TIMEOUT_CYC, the handshake wins and no fault is raised.
REQ-023 ERROR: error=1, all enables 0; exit only by reset.

Reset
REQ-024 Reset SHALL immediately force state=IDLE, wait counter=0 and latched opcode=0, independent of clk.
REQ-025 During and after reset every output SHALL be 0, state=0000; reset asserted mid-instruction SHALL abandon it with no write enable pulse.

Configuration
REQ-026 Macro MC_CTRL_BRANCH_EN: when defined, BEQ (1100011) is supported: EXECUTE drives aluop=01, wePc=1, instr_done=1 and pc_src=01 if zero=1, else 00; next state FETCH/IDLE per REQ-018.
REQ-027 Without MC_CTRL_BRANCH_EN, 1100011 SHALL be illegal (DECODE -> ERROR) and pc_src SHALL be constant 00.

Verification
REQ-028 Reset, run=1, opcode=0110011, mem_ready=1 -> states 1,2,3,5,1; weReg=1 in WRITE_BACK; wePc=1 and instr_done=1 once; 4 cycles per instruction.
REQ-029 LW with mem_ready low for 3 cycles in MEM -> MEM lasts 4 cycles; wb_sel=1 and weReg=1 in WRITE_BACK; no error.
REQ-030 SW -> weMem=1 only in MEM; wePc=1 on the mem_ready cycle; weReg never asserted.
REQ-031 mem_ready held 0 in FETCH, TIMEOUT_CYC=4 -> ERROR after 4 wait cycles; error stays 1 until reset; busy=0.
REQ-032 opcode=1100011, zero=1 -> with MC_CTRL_BRANCH_EN: pc_src=01 and wePc=1 in EXECUTE; without it: state ERROR after DECODE.
REQ-033 reset asserted in MEM during SW -> state=0 and weMem=0 the same cycle; run=0 afterwards -> remains IDLE.
